risc16_mc_ctrl: RTL and testbench

RISC16_MC_CTRL -- requirements
Module: risc16_mc_ctrl

---
 rtl/risc16_pkg.sv | 54 +++++
 rtl/risc16_decode.sv | 24 ++
 rtl/risc16_mc_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_risc16_mc_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc16_pkg.sv
// Shared types and constants for the RISC16 multi-cycle controller.
package risc16_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_LD    = 4'b0000;
    localparam logic [3:0] OP_ST    = 4'b0001;
    localparam logic [3:0] OP_ILL_A = 4'b1010;
    localparam logic [3:0] OP_BEQ   = 4'b1011;
    localparam logic [3:0] OP_BNE   = 4'b1100;
    localparam logic [3:0] OP_JMP   = 4'b1101;
    localparam logic [3:0] OP_ILL_B = 4'b1110;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    localparam logic [1:0] ALU_ADDR = 2'b00;
    localparam logic [1:0] ALU_CMP  = 2'b01;
    localparam logic [1:0] ALU_FUNC = 2'b10;

    // One-hot class of an opcode; exactly one field is set.
    typedef struct packed {
        logic is_ld;
        logic is_st;
        logic is_alu;
        logic is_beq;
        logic is_bne;
        logic is_jmp;
        logic is_halt;
        logic is_illegal;
    } op_class_t;

    // Bundle of every datapath control the FSM drives.
    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic       jump;
        logic       beq;
        logic       bne;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/risc16_decode.sv
// Combinational opcode classifier for the RISC16 controller.
module risc16_decode
    import risc16_pkg::*;
(
    input  logic [3:0] opcode,
    output op_class_t  cls
);

    // Map each opcode to its class; 0010-1001 are all register ALU ops.
    always_comb begin
        cls = '0;
        case (opcode)
            OP_LD:              cls.is_ld      = 1'b1;
            OP_ST:              cls.is_st      = 1'b1;
            OP_BEQ:             cls.is_beq     = 1'b1;
            OP_BNE:             cls.is_bne     = 1'b1;
            OP_JMP:             cls.is_jmp     = 1'b1;
            OP_HALT:            cls.is_halt    = 1'b1;
            OP_ILL_A, OP_ILL_B: cls.is_illegal = 1'b1;
            default:            cls.is_alu     = 1'b1;
        endcase
    end

endmodule

// File: rtl/risc16_mc_ctrl.sv
// Multi-cycle control FSM for the RISC16 datapath.
//
// state  | meaning
// FETCH  | wait for run, then load the instruction register
// DECODE | capture opcode into op_q and classify it
// EXEC   | ALU step: address add, register op, branch compare or jump
// MEM    | hold the data-memory access until mem_ready or timeout
// WB     | write the register file and advance the PC
// HALT   | absorbing stop; only reset leaves it
module risc16_mc_ctrl
    import risc16_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [3:0]  opcode,
    input  logic        mem_ready,
    output logic        ir_write,
    output logic        pc_write,
    output logic        jump,
    output logic        beq,
    output logic        bne,
    output logic        mem_read,
    output logic        mem_write,
    output logic        alu_src,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic [1:0]  alu_op,
    output logic        halted,
    output logic        illegal,
    output logic        bus_err,
    output logic [2:0]  state,
    output logic [15:0] retired
);

    localparam int WAIT_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MEM_WAIT_MAX);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(1);

    state_t            state_q, state_d;
    logic [3:0]        op_q;
    logic [3:0]        dec_op;
    op_class_t         cls;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [15:0]       retired_q;
    logic              halted_q, illegal_q, bus_err_q;
    logic              set_illegal, set_bus_err;
    ctrl_t             ctrl_c, ctrl_g;

    // In DECODE the live opcode is classified; everywhere else the latched
    // copy is, so opcode wiggles outside DECODE cannot reach the outputs.
    assign dec_op = (state_q == S_DECODE) ? opcode : op_q;

    risc16_decode u_decode (
        .opcode (dec_op),
        .cls    (cls)
    );

    // Next state, wait-timer and control decode.
    // Controls depend on state and op_q, except the ST pc_write in MEM, which
    // must coincide with the mem_ready cycle to keep one pc_write per store.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        ctrl_c      = '0;
        set_illegal = 1'b0;
        set_bus_err = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (run) begin
                    ctrl_c.ir_write = 1'b1;
                    state_d         = S_DECODE;
                end
            end
            S_DECODE: begin
                if (cls.is_halt) begin
                    state_d = S_HALT;
                end else if (cls.is_illegal) begin
                    state_d     = S_HALT;
                    set_illegal = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cls.is_ld || cls.is_st) begin
                    ctrl_c.alu_op  = ALU_ADDR;
                    ctrl_c.alu_src = 1'b1;
                    wait_cnt_d     = WAIT_LOAD;
                    state_d        = S_MEM;
                end else if (cls.is_beq || cls.is_bne) begin
                    ctrl_c.beq      = cls.is_beq;
                    ctrl_c.bne      = cls.is_bne;
                    ctrl_c.alu_op   = ALU_CMP;
                    ctrl_c.pc_write = 1'b1;
                    state_d         = S_FETCH;
                end else if (cls.is_jmp) begin
                    ctrl_c.jump     = 1'b1;
                    ctrl_c.pc_write = 1'b1;
                    state_d         = S_FETCH;
                end else begin
                    ctrl_c.alu_op  = ALU_FUNC;
                    ctrl_c.alu_src = 1'b0;
                    state_d        = S_WB;
                end
            end
            S_MEM: begin
                ctrl_c.alu_op    = ALU_ADDR;
                ctrl_c.alu_src   = 1'b1;
                ctrl_c.mem_read  = cls.is_ld;
                ctrl_c.mem_write = cls.is_st;
                if (mem_ready) begin
                    if (cls.is_ld) begin
                        state_d = S_WB;
                    end else begin
                        ctrl_c.pc_write = 1'b1;
                        state_d         = S_FETCH;
                    end
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d     = S_HALT;
                    set_bus_err = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q - WAIT_LAST;
                end
            end
            S_WB: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.pc_write   = 1'b1;
                ctrl_c.mem_to_reg = cls.is_ld;
                ctrl_c.reg_dst    = ~cls.is_ld;
                state_d           = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // State, latched opcode, wait timer, retire counter and sticky flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            op_q       <= '0;
            wait_cnt_q <= '0;
            retired_q  <= '0;
            halted_q   <= 1'b0;
            illegal_q  <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            retired_q  <= retired_q + {15'd0, ctrl_c.pc_write};
            if (state_q == S_DECODE) begin
                op_q <= opcode;
            end
            if (state_d == S_HALT) begin
                halted_q <= 1'b1;
            end
            if (set_illegal) begin
                illegal_q <= 1'b1;
            end
            if (set_bus_err) begin
                bus_err_q <= 1'b1;
            end
        end
    end

    // Controls are forced low for as long as reset is held.
    assign ctrl_g = rst_n ? ctrl_c : '0;

    assign ir_write   = ctrl_g.ir_write;
    assign pc_write   = ctrl_g.pc_write;
    assign jump       = ctrl_g.jump;
    assign beq        = ctrl_g.beq;
    assign bne        = ctrl_g.bne;
    assign mem_read   = ctrl_g.mem_read;
    assign mem_write  = ctrl_g.mem_write;
    assign alu_src    = ctrl_g.alu_src;
    assign reg_dst    = ctrl_g.reg_dst;
    assign mem_to_reg = ctrl_g.mem_to_reg;
    assign reg_write  = ctrl_g.reg_write;
    assign alu_op     = ctrl_g.alu_op;

    assign halted  = halted_q;
    assign illegal = illegal_q;
    assign bus_err = bus_err_q;
    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_risc16_mc_ctrl.sv
// Self-checking bench for risc16_mc_ctrl: per-instruction cycle plans feed an
// expectation queue that a negedge process compares against the DUT.
module tb_risc16_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic [3:0]  opcode = 4'h0;
    logic        mem_ready = 1'b0;
    logic        ir_write, pc_write, jump, beq, bne, mem_read, mem_write;
    logic        alu_src, reg_dst, mem_to_reg, reg_write;
    logic [1:0]  alu_op;
    logic        halted, illegal, bus_err;
    logic [2:0]  state;
    logic [15:0] retired;

    risc16_mc_ctrl #(.MEM_WAIT_MAX(15)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .jump       (jump),
        .beq        (beq),
        .bne        (bne),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .alu_src    (alu_src),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_op     (alu_op),
        .halted     (halted),
        .illegal    (illegal),
        .bus_err    (bus_err),
        .state      (state),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    // Control vector layout: ir pc jmp beq bne mr mw asrc rd m2r rw aluop[1:0]
    localparam logic [12:0] C_IR   = 13'h1000;
    localparam logic [12:0] C_PC   = 13'h0800;
    localparam logic [12:0] C_JMP  = 13'h0400;
    localparam logic [12:0] C_BEQ  = 13'h0200;
    localparam logic [12:0] C_BNE  = 13'h0100;
    localparam logic [12:0] C_MR   = 13'h0080;
    localparam logic [12:0] C_MW   = 13'h0040;
    localparam logic [12:0] C_ASRC = 13'h0020;
    localparam logic [12:0] C_RD   = 13'h0010;
    localparam logic [12:0] C_M2R  = 13'h0008;
    localparam logic [12:0] C_RW   = 13'h0004;
    localparam logic [12:0] C_A10  = 13'h0002;
    localparam logic [12:0] C_A01  = 13'h0001;

    localparam logic [2:0] ST_F = 3'd0, ST_D = 3'd1, ST_E = 3'd2;
    localparam logic [2:0] ST_M = 3'd3, ST_W = 3'd4, ST_H = 3'd5;

    typedef struct {
        logic [2:0]  st;
        logic [12:0] ctl;
        logic [2:0]  flg;
        logic [15:0] ret;
        string       tag;
    } exp_t;

    exp_t        expq[$];
    exp_t        e_cur;
    int          checks = 0;
    int          errs = 0;
    logic [15:0] m_ret = 16'd0;
    logic        m_halt = 1'b0, m_ill = 1'b0, m_bus = 1'b0;
    int          cur_len = 0, last_len = 0, pc_cnt = 0, mr_cnt = 0, mw_cnt = 0;
    int          pc_before = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Compare process plus a few independent activity counters.
    always @(negedge clk) begin
        if (ir_write) cur_len = 1;
        else if (cur_len > 0) cur_len++;
        if (pc_write) begin
            last_len = cur_len;
            cur_len  = 0;
            pc_cnt++;
        end
        if (mem_read) mr_cnt++;
        if (mem_write) mw_cnt++;
        if (expq.size() > 0) begin
            e_cur = expq.pop_front();
            chk({e_cur.tag, ".state"}, 32'(state), 32'(e_cur.st));
            chk({e_cur.tag, ".ctl"},
                32'({ir_write, pc_write, jump, beq, bne, mem_read, mem_write,
                     alu_src, reg_dst, mem_to_reg, reg_write, alu_op}),
                32'(e_cur.ctl));
            chk({e_cur.tag, ".flags"}, 32'({halted, illegal, bus_err}), 32'(e_cur.flg));
            chk({e_cur.tag, ".retired"}, 32'(retired), 32'(e_cur.ret));
        end
    end

    // Drive one cycle's inputs just after the rising edge and queue what the
    // outputs must be during that cycle.
    task automatic cyc(input logic run_i, input logic [3:0] op_i, input logic rdy_i,
                       input logic rst_i, input logic [2:0] st_e, input logic [12:0] ctl_e,
                       input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        run       = run_i;
        opcode    = op_i;
        mem_ready = rdy_i;
        rst_n     = rst_i;
        e.st  = st_e;
        e.ctl = ctl_e;
        e.flg = {m_halt, m_ill, m_bus};
        e.ret = m_ret;
        e.tag = tag;
        expq.push_back(e);
        if (!rst_i) begin
            m_ret  = 16'd0;
            m_halt = 1'b0;
            m_ill  = 1'b0;
            m_bus  = 1'b0;
        end else if ((ctl_e & C_PC) != 13'd0) begin
            m_ret = m_ret + 16'd1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 4'h3, 1'b1, 1'b1, ST_F, 13'd0, "idle");
    endtask

    task automatic rst_cycle(input logic [2:0] st_cur);
        cyc(1'b0, 4'h0, 1'b1, 1'b0, st_cur, 13'd0, "reset");
    endtask

    // Cycle plan for one instruction starting in FETCH; waits = mem_ready-low
    // cycles in MEM, 15 or more means the bus times out.
    task automatic do_instr(input logic [3:0] op, input int waits, input string tag);
        logic [3:0]  junk;
        logic [12:0] macc;
        junk = ~op;
        cyc(1'b1, op, 1'b0, 1'b1, ST_F, C_IR, tag);
        cyc(1'b1, op, 1'b1, 1'b1, ST_D, 13'd0, tag);
        if (op == 4'hF || op == 4'hA || op == 4'hE) begin
            m_halt = 1'b1;
            if (op != 4'hF) m_ill = 1'b1;
            cyc(1'b1, junk, 1'b1, 1'b1, ST_H, 13'd0, tag);
            cyc(1'b1, 4'h0, 1'b1, 1'b1, ST_H, 13'd0, tag);
            return;
        end
        case (op)
            4'h0, 4'h1: begin
                macc = (op == 4'h0) ? C_MR : C_MW;
                cyc(1'b1, junk, 1'b1, 1'b1, ST_E, C_ASRC, tag);
                for (int i = 0; i < waits && i < 15; i++)
                    cyc(1'b1, junk, 1'b0, 1'b1, ST_M, C_ASRC | macc, tag);
                if (waits >= 15) begin
                    m_halt = 1'b1;
                    m_bus  = 1'b1;
                    cyc(1'b1, junk, 1'b1, 1'b1, ST_H, 13'd0, tag);
                    cyc(1'b1, junk, 1'b1, 1'b1, ST_H, 13'd0, tag);
                end else if (op == 4'h0) begin
                    cyc(1'b1, junk, 1'b1, 1'b1, ST_M, C_ASRC | C_MR, tag);
                    cyc(1'b1, junk, 1'b0, 1'b1, ST_W, C_RW | C_PC | C_M2R, tag);
                end else begin
                    cyc(1'b1, junk, 1'b1, 1'b1, ST_M, C_ASRC | C_MW | C_PC, tag);
                end
            end
            4'hB: cyc(1'b1, junk, 1'b1, 1'b1, ST_E, C_BEQ | C_PC | C_A01, tag);
            4'hC: cyc(1'b1, junk, 1'b1, 1'b1, ST_E, C_BNE | C_PC | C_A01, tag);
            4'hD: cyc(1'b1, junk, 1'b1, 1'b1, ST_E, C_JMP | C_PC, tag);
            default: begin
                cyc(1'b1, junk, 1'b1, 1'b1, ST_E, C_A10, tag);
                cyc(1'b1, junk, 1'b1, 1'b1, ST_W, C_RW | C_PC | C_RD, tag);
            end
        endcase
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_cycle(ST_F);
        rst_cycle(ST_F);
        idle(2);
        #1;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_retired", 32'(retired), 32'd0);
        chk("reset_flags", 32'({halted, illegal, bus_err}), 32'd0);

        do_instr(4'h2, 0, "rtype2");
        idle(1); #1;
        chk("rtype_len", 32'(last_len), 32'd4);
        chk("rtype_retired", 32'(retired), 32'd1);
        do_instr(4'h9, 0, "rtype9");
        do_instr(4'h5, 0, "rtype5");

        mr_cnt = 0;
        do_instr(4'h0, 3, "ld_w3");
        idle(1); #1;
        chk("ld_w3_memread_cycles", 32'(mr_cnt), 32'd4);
        chk("ld_w3_len", 32'(last_len), 32'd8);

        do_instr(4'h0, 0, "ld_w0");
        idle(1); #1;
        chk("ld_w0_len", 32'(last_len), 32'd5);
        do_instr(4'h1, 2, "st_w2");
        idle(1); #1;
        chk("st_w2_len", 32'(last_len), 32'd6);

        do_instr(4'hB, 0, "beq");
        idle(1); #1;
        chk("beq_len", 32'(last_len), 32'd3);
        do_instr(4'hC, 0, "bne");
        do_instr(4'hD, 0, "jmp");

        do_instr(4'h0, 14, "ld_w14");
        idle(1); #1;
        chk("ld_w14_len", 32'(last_len), 32'd19);
        chk("ld_w14_no_buserr", 32'(bus_err), 32'd0);

        mw_cnt = 0;
        do_instr(4'h1, 15, "st_timeout");
        #1;
        chk("st_timeout_bus_err", 32'(bus_err), 32'd1);
        chk("st_timeout_halted", 32'(halted), 32'd1);
        chk("st_timeout_mem_write", 32'(mem_write), 32'd0);
        chk("st_timeout_mw_cycles", 32'(mw_cnt), 32'd15);
        rst_cycle(ST_H);
        idle(1);

        pc_before = pc_cnt;
        do_instr(4'hA, 0, "ill_a");
        #1;
        chk("ill_a_illegal", 32'(illegal), 32'd1);
        chk("ill_a_halted", 32'(halted), 32'd1);
        rst_cycle(ST_H);
        idle(1); #1;
        chk("ill_a_no_pc_write", 32'(pc_cnt - pc_before), 32'd0);
        chk("ill_a_reset_state", 32'(state), 32'd0);
        chk("ill_a_reset_flags", 32'({halted, illegal, bus_err}), 32'd0);

        do_instr(4'hE, 0, "ill_b");
        rst_cycle(ST_H);
        idle(1);
        do_instr(4'hF, 0, "halt");
        #1;
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_not_illegal", 32'(illegal), 32'd0);
        rst_cycle(ST_H);
        idle(1);

        pc_before = pc_cnt;
        cyc(1'b1, 4'h0, 1'b0, 1'b1, ST_F, C_IR, "abort");
        cyc(1'b1, 4'h0, 1'b0, 1'b1, ST_D, 13'd0, "abort");
        cyc(1'b1, 4'h7, 1'b0, 1'b1, ST_E, C_ASRC, "abort");
        cyc(1'b1, 4'h7, 1'b0, 1'b1, ST_M, C_ASRC | C_MR, "abort");
        rst_cycle(ST_M);
        idle(2); #1;
        chk("abort_no_pc_write", 32'(pc_cnt - pc_before), 32'd0);
        chk("abort_state", 32'(state), 32'd0);

        repeat (100) do_instr(4'hD, 0, "jmp_run");
        idle(1); #1;
        chk("jmp_run_retired", 32'(retired), 32'd100);

        @(negedge clk);
        #1;
        force dut.retired_q = 16'hFFFE;
        m_ret = 16'hFFFE;
        idle(1);
        release dut.retired_q;
        do_instr(4'hD, 0, "jmp_ffff");
        idle(1); #1;
        chk("retired_ffff", 32'(retired), 32'h0000FFFF);
        do_instr(4'hD, 0, "jmp_wrap");
        idle(1); #1;
        chk("retired_wrap", 32'(retired), 32'd0);

        for (int i = 0; i < 20 && expq.size() > 0; i++) @(negedge clk);
        if (expq.size() != 0) begin
            checks++;
            errs++;
            $display("FAIL drain actual=%0d required=0 pending expectations", expq.size());
        end
        #1;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
